// File: rtl/psram_req_queue.sv
// In-order request queue and issue sequencer in front of the PSRAM controller.
// Controller inputs are loaded when a request issues and held until busy drops.
module psram_req_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 22
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_we,
  input  logic [AW-1:0]            req_addr,
  input  logic [15:0]              req_wdata,
  input  logic                     req_byte,
  output logic                     rsp_valid,
  output logic [15:0]              rsp_rdata,
  output logic [$clog2(DEPTH):0]   pending,
  output logic                     mem_read,
  output logic                     mem_write,
  output logic [AW-1:0]            mem_addr,
  output logic [15:0]              mem_din,
  output logic                     mem_byte_write,
  input  logic [15:0]              mem_dout,
  input  logic                     mem_busy
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int EW = AW + 18;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_DONE = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic            wb_cnt;
  logic            wb_cnt_next;
  logic [EW-1:0]   fifo_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic [EW-1:0]   head;
  logic            head_we;
  logic            head_byte;
  logic [AW-1:0]   head_addr;
  logic [15:0]     head_wdata;
  logic            push;
  logic            pop;
  logic            issue_next;

  // Entry layout is {we, byte, addr, wdata}.
  assign head       = fifo_mem[rd_ptr];
  assign head_we    = head[EW-1];
  assign head_byte  = head[EW-2];
  assign head_addr  = head[AW+15:16];
  assign head_wdata = head[15:0];

  assign push       = req_valid && req_ready;
  assign pop        = (state == WAIT_DONE) && !mem_busy;
  assign issue_next = (state_next == ISSUE);

  // Entry storage; contents are don't-care while a slot is free.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr] <= {req_we, req_byte, req_addr, req_wdata};
    end
  end

  // Occupancy after this cycle's push and pop.
  always_comb begin
    count_next = pending;
    case ({push, pop})
      2'b10:   count_next = pending + CW'(1);
      2'b01:   count_next = pending - CW'(1);
      default: count_next = pending;
    endcase
  end

  // Pointers, occupancy and ready; ready depends only on registered occupancy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr    <= {PW{1'b0}};
      rd_ptr    <= {PW{1'b0}};
      pending   <= {CW{1'b0}};
      req_ready <= 1'b1;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      pending   <= count_next;
      req_ready <= (count_next != FULL);
    end
  end

  // Issue sequencer next-state; a missing busy rise after two cycles re-strobes.
  always_comb begin
    state_next  = state;
    wb_cnt_next = wb_cnt;
    case (state)
      IDLE: begin
        if ((pending != {CW{1'b0}}) && !mem_busy) begin
          state_next = ISSUE;
        end else begin
          state_next = IDLE;
        end
      end
      ISSUE: begin
        state_next  = WAIT_BUSY;
        wb_cnt_next = 1'b0;
      end
      WAIT_BUSY: begin
        if (mem_busy) begin
          state_next = WAIT_DONE;
        end else if (wb_cnt) begin
          state_next = ISSUE;
        end else begin
          wb_cnt_next = 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!mem_busy) begin
          state_next = IDLE;
        end else begin
          state_next = WAIT_DONE;
        end
      end
      default: begin
        state_next  = IDLE;
        wb_cnt_next = 1'b0;
      end
    endcase
  end

  // State register, strobes, held controller inputs and the read response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= IDLE;
      wb_cnt         <= 1'b0;
      mem_read       <= 1'b0;
      mem_write      <= 1'b0;
      mem_addr       <= {AW{1'b0}};
      mem_din        <= 16'h0000;
      mem_byte_write <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_rdata      <= 16'h0000;
    end else begin
      state     <= state_next;
      wb_cnt    <= wb_cnt_next;
      mem_read  <= issue_next && !head_we;
      mem_write <= issue_next && head_we;
      // The head cannot change between ISSUE and the pop, so reloading on re-strobe is harmless.
      if (issue_next) begin
        mem_addr       <= head_addr;
        mem_din        <= head_wdata;
        mem_byte_write <= head_byte;
      end
      rsp_valid <= pop && !head_we;
      if (pop && !head_we) begin
        rsp_rdata <= mem_dout;
      end
    end
  end

endmodule

// File: tb/tb_psram_req_queue.sv
// Self-checking bench for psram_req_queue: behavioural controller model, in-order
// reference scoreboard, directed vector table, corner-case sequences and random traffic.
module tb_psram_req_queue;

  localparam int DEPTH = 4;
  localparam int AW    = 22;
  localparam int PCW   = $clog2(DEPTH) + 1;

  typedef struct {
    logic          we;
    logic          bw;
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } req_t;

  typedef struct {
    logic          we;
    logic          bw;
    logic [AW-1:0] addr;
    logic [15:0]   wdata;
    logic [15:0]   exp_rdata;
  } vec_t;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic            req_valid = 1'b0;
  logic            req_we = 1'b0;
  logic            req_byte = 1'b0;
  logic [AW-1:0]   req_addr = '0;
  logic [15:0]     req_wdata = 16'h0000;
  logic            req_ready;
  logic            rsp_valid;
  logic [15:0]     rsp_rdata;
  logic [PCW-1:0]  pending;
  logic            mem_read;
  logic            mem_write;
  logic [AW-1:0]   mem_addr;
  logic [15:0]     mem_din;
  logic            mem_byte_write;
  logic [15:0]     mem_dout = 16'h0000;
  logic            mem_busy = 1'b1;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  psram_req_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_byte(req_byte),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .pending(pending),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_byte_write(mem_byte_write),
    .mem_dout(mem_dout), .mem_busy(mem_busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference memory: unwritten words read back a fixed address-derived pattern.
  logic [15:0] ref_mem [int];
  logic [15:0] ctl_mem [int];
  req_t        issue_q [$];
  logic [15:0] exp_q [$];

  function automatic logic [15:0] init_val(input int w);
    return 16'hA5C3 ^ w[15:0] ^ 16'h0008;
  endfunction

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] din,
                                        input logic bw, input logic a0);
    if (!bw) return din;
    if (a0) return {din[15:8], old[7:0]};
    return {old[15:8], din[7:0]};
  endfunction

  function automatic logic [15:0] ref_get(input int w);
    if (ref_mem.exists(w)) return ref_mem[w];
    return init_val(w);
  endfunction

  function automatic logic [15:0] ctl_get(input int w);
    if (ctl_mem.exists(w)) return ctl_mem[w];
    return init_val(w);
  endfunction

  // Accept monitor: requests take effect on the reference in acceptance order.
  int   n_accepted = 0;
  int   mon_w;
  req_t mon_r;
  always @(posedge clk) begin
    if (reset) begin
      issue_q.delete();
      exp_q.delete();
    end else if (req_valid && req_ready) begin
      n_accepted++;
      mon_r = '{req_we, req_byte, req_addr, req_wdata};
      issue_q.push_back(mon_r);
      mon_w = int'(req_addr >> 1);
      if (req_we) ref_mem[mon_w] = merge(ref_get(mon_w), req_wdata, req_byte, req_addr[0]);
      else exp_q.push_back(ref_get(mon_w));
    end
  end

  // Controller model plus response / strobe / hold checking, all on the falling edge.
  bit          hold_busy = 1'b1;
  bit          never_busy = 1'b0;
  int          lat_fixed = 0;
  int          busy_cnt = 0;
  int          cyc = 0;
  int          rsp_due = -1;
  int          strobes = 0;
  int          n_done = 0;
  int          ctl_w;
  logic        prev_strobe = 1'b0;
  logic [15:0] last_rsp = 16'h0000;
  logic [15:0] exp_tmp;
  req_t        cur;

  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      busy_cnt    = 0;
      mem_busy    = hold_busy;
      prev_strobe = 1'b0;
      last_rsp    = 16'h0000;
    end else begin
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("rsp_unexpected", 32'd1, 32'd0);
        end else begin
          exp_tmp = exp_q.pop_front();
          check("rsp_rdata", rsp_rdata, exp_tmp);
          check("rsp_latency", cyc, rsp_due);
        end
        last_rsp = rsp_rdata;
      end else begin
        check("rsp_hold", rsp_rdata, last_rsp);
      end

      if (mem_read || mem_write) begin
        strobes++;
        check("strobe_exclusive", mem_read & mem_write, 32'd0);
        check("strobe_single_cycle", prev_strobe, 32'd0);
        check("strobe_while_busy", mem_busy, 32'd0);
        if (issue_q.size() == 0) begin
          check("strobe_unexpected", 32'd1, 32'd0);
        end else begin
          check("issue_addr", mem_addr, issue_q[0].addr);
          check("issue_we", mem_write, issue_q[0].we);
          check("issue_byte", mem_byte_write, issue_q[0].bw);
          if (issue_q[0].we) check("issue_din", mem_din, issue_q[0].data);
        end
      end
      prev_strobe = mem_read | mem_write;

      if (busy_cnt > 0) begin
        check("hold_addr", mem_addr, cur.addr);
        check("hold_byte", mem_byte_write, cur.bw);
        if (cur.we) check("hold_din", mem_din, cur.data);
        busy_cnt--;
        if (busy_cnt == 0) begin
          ctl_w = int'(cur.addr >> 1);
          if (cur.we) begin
            ctl_mem[ctl_w] = merge(ctl_get(ctl_w), cur.data, cur.bw, cur.addr[0]);
          end else begin
            mem_dout = ctl_get(ctl_w);
            rsp_due  = cyc + 1;
          end
          mem_busy = 1'b0;
          n_done++;
          if (issue_q.size() > 0) void'(issue_q.pop_front());
        end
      end else if ((mem_read || mem_write) && !never_busy) begin
        cur      = '{mem_write, mem_byte_write, mem_addr, mem_din};
        busy_cnt = (lat_fixed > 0) ? lat_fixed : $urandom_range(5, 2);
        mem_busy = 1'b1;
        mem_dout = 16'($urandom);
      end else begin
        mem_busy = hold_busy;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic push(input logic we, input logic bw, input logic [AW-1:0] addr,
                      input logic [15:0] data);
    int n;
    req_valid = 1'b1;
    req_we    = we;
    req_byte  = bw;
    req_addr  = addr;
    req_wdata = data;
    n = 0;
    while (!req_ready && n < 5000) begin
      tick();
      n++;
    end
    if (n >= 5000) check("push_timeout", 32'd0, 32'd1);
    else tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((pending != '0 || exp_q.size() != 0 || rsp_valid) && n < 3000) begin
      tick();
      n++;
    end
    if (n >= 3000) check("drain_timeout", 32'd0, 32'd1);
  endtask

  vec_t vec [7];

  initial begin
    int n;
    int base;
    vec[0] = '{1'b0, 1'b0, 22'h000010, 16'h0000, 16'hA5C3};
    vec[1] = '{1'b1, 1'b0, 22'h000020, 16'h1234, 16'h0000};
    vec[2] = '{1'b0, 1'b0, 22'h000020, 16'h0000, 16'h1234};
    vec[3] = '{1'b1, 1'b1, 22'h000021, 16'hBE00, 16'h0000};
    vec[4] = '{1'b0, 1'b0, 22'h000020, 16'h0000, 16'hBE34};
    vec[5] = '{1'b1, 1'b1, 22'h000020, 16'h77CD, 16'h0000};
    vec[6] = '{1'b0, 1'b0, 22'h000021, 16'h0000, 16'hBECD};

    repeat (4) tick();
    check("rst_req_ready", req_ready, 32'd1);
    check("rst_pending", pending, 32'd0);
    check("rst_rsp_valid", rsp_valid, 32'd0);
    check("rst_rsp_rdata", rsp_rdata, 32'd0);
    check("rst_strobes", {mem_read, mem_write, mem_byte_write}, 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_din", mem_din, 32'd0);
    reset = 1'b0;

    // Directed table; the first entry waits behind a long controller init.
    for (int i = 0; i < 7; i++) begin
      push(vec[i].we, vec[i].bw, vec[i].addr, vec[i].wdata);
      if (i == 0) begin
        repeat (195) tick();
        check("init_no_strobe", strobes, 32'd0);
        check("init_pending", pending, 32'd1);
        hold_busy = 1'b0;
      end
      wait_idle();
      if (!vec[i].we) check("vec_rdata", last_rsp, vec[i].exp_rdata);
    end

    // Read into an empty queue: strobe two cycles after acceptance, one cycle wide.
    push(1'b0, 1'b0, 22'h000010, 16'h0000);
    check("lat_not_early", mem_read, 32'd0);
    tick();
    check("lat_issue", mem_read, 32'd1);
    tick();
    check("lat_strobe_width", mem_read, 32'd0);
    wait_idle();

    // Write then read of the same address queued back to back.
    push(1'b1, 1'b0, 22'h000040, 16'hC0DE);
    push(1'b0, 1'b0, 22'h000040, 16'h0000);
    wait_idle();
    check("wr_rd_same_addr", last_rsp, 32'h0000C0DE);

    // Controller stuck busy: four accepted, fifth held until busy releases.
    hold_busy = 1'b1;
    tick();
    base = n_done;
    for (int k = 0; k < 4; k++) push(k[0], 1'b0, AW'(22'h000080 + 2 * k), 16'(16'h1100 + k));
    check("full_ready", req_ready, 32'd0);
    check("full_pending", pending, 32'd4);
    req_valid = 1'b1;
    req_we    = 1'b0;
    req_byte  = 1'b0;
    req_addr  = 22'h000082;
    repeat (10) tick();
    check("full_held_pending", pending, 32'd4);
    check("full_held_strobes", mem_read | mem_write, 32'd0);
    hold_busy = 1'b0;
    n = 0;
    while (!req_ready && n < 500) begin
      tick();
      n++;
    end
    check("full_fifth_accepted", req_ready, 32'd1);
    tick();
    req_valid = 1'b0;
    wait_idle();
    check("full_all_done", n_done - base, 32'd5);
    check("full_drained", pending, 32'd0);
    check("full_last_rsp", last_rsp, 32'h00001101);

    // Reset while a read sits in WAIT_DONE.
    lat_fixed = 20;
    push(1'b0, 1'b0, 22'h000010, 16'h0000);
    n = 0;
    while (!mem_busy && n < 50) begin
      tick();
      n++;
    end
    repeat (3) tick();
    reset = 1'b1;
    #1;
    check("mid_rst_rsp_valid", rsp_valid, 32'd0);
    check("mid_rst_pending", pending, 32'd0);
    check("mid_rst_ready", req_ready, 32'd1);
    check("mid_rst_mem", {mem_read, mem_write, mem_byte_write, mem_addr}, 32'd0);
    check("mid_rst_din", mem_din, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    lat_fixed = 0;
    repeat (30) tick();
    check("post_rst_pending", pending, 32'd0);
    check("post_rst_ready", req_ready, 32'd1);

    // Busy never rises: the write is re-strobed every three cycles.
    never_busy = 1'b1;
    push(1'b1, 1'b0, 22'h000060, 16'h5A5A);
    n = 0;
    while (!mem_write && n < 20) begin
      tick();
      n++;
    end
    check("nb_first_strobe", mem_write, 32'd1);
    for (int k = 0; k < 2; k++) begin
      tick();
      n = 1;
      while (!mem_write && n < 20) begin
        tick();
        n++;
      end
      check("nb_restrobe_gap", n, 32'd3);
    end
    never_busy = 1'b0;
    wait_idle();
    push(1'b0, 1'b0, 22'h000060, 16'h0000);
    wait_idle();
    check("nb_readback", last_rsp, 32'h00005A5A);

    // Random traffic over a small address window.
    for (int k = 0; k < 150; k++) begin
      push(1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
           AW'(22'h000100 + $urandom_range(15, 0)), 16'($urandom));
      repeat ($urandom_range(2, 0)) tick();
    end
    wait_idle();
    check("final_pending", pending, 32'd0);
    check("final_ready", req_ready, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

endmodule
